dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 64, number of 32-bit RAM words (power of two, 4..64).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (fixed at 4 for this revision).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-low (asserted when 0, sampled on clk rising edge).
REQ-005 SHALL have port memwrite  input  1  processor store strobe for the current cycle.
REQ-006 SHALL have port addr  input  32  processor byte address (ALU result).
REQ-007 SHALL have port writedata  input  32  processor store data.
REQ-008 SHALL have port readdata  output  32  load data returned to the processor in the same cycle.
REQ-009 SHALL have port out_data  output  32  FIFO head word to the external consumer.
REQ-010 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port out_ready  input  1  consumer accepts head this cycle.

Function
REQ-012 SHALL decode addr[31:8]==24'h000000 as RAM, word index addr[7:2] mod RAM_WORDS; addr[1:0] ignored everywhere.
REQ-013 SHALL decode addr[31:8]==24'hFFFFFF as I/O: offset 0x00 CNT, 0x04 FIFO, 0x08 STAT; other I/O offsets read 0, writes ignored.
REQ-014 SHALL treat all other addresses as unmapped: readdata 0, writes ignored, no state change.
REQ-015 SHALL drive readdata combinationally from current state and addr, independent of memwrite (zero-latency load for single-cycle core).
REQ-016 SHALL write RAM on rising edge when memwrite=1 and address is RAM; read of same word in the same cycle returns old value.
REQ-017 CNT: 32-bit free-running counter, +1 every cycle, wraps 0xFFFFFFFF->0; store to CNT loads writedata (load wins, no increment that cycle); read returns current value.
REQ-018 FIFO: store to FIFO offset pushes writedata at tail; read of FIFO offset returns head word (no pop).
REQ-019 Pop occurs on edge where out_valid=1 and out_ready=1; out_data=head, out_valid=(count!=0).
REQ-020 Push when full and no pop same cycle: data dropped, FIFO unchanged, DROP counter +1 saturating at 255.
REQ-021 Push when full with pop same cycle: push accepted, count stays 4, order preserved.
REQ-022 Push and pop when 0<count<4: both performed, count unchanged; push when empty: out_valid rises next cycle (1-cycle latency, no bypass).
REQ-023 out_ready when empty: no effect; pointers are 2-bit and wrap modulo 4.
REQ-024 STAT read: bits[2:0]=count (0..4), bit3=full, bit4=empty, bits[15:8]=DROP, other bits 0.
REQ-025 Store to STAT clears DROP to 0; if a dropped push coincides it cannot (single port), so no conflict.
REQ-026 Outputs out_data SHALL equal 0 when empty.

Reset
REQ-027 On clk edge with reset=0: CNT=0, FIFO count=0, pointers=0, DROP=0; out_valid=0 and out_data=0 from the next cycle.
REQ-028 Reset SHALL override any same-cycle store, push or pop; entries pending at reset are discarded.
REQ-029 RAM contents SHALL NOT be reset; RAM reads before first write are unspecified (bench must not check).
REQ-030 First CNT increment occurs on the first edge with reset=1 (CNT reads 1 one cycle after release).

Verification
REQ-031 Store 0xDEADBEEF to addr 0x10, load 0x10 next cycle -> readdata 0xDEADBEEF; load 0x13 -> same; load 0x00001010 -> 0.
REQ-032 Release reset, hold 10 cycles -> CNT reads 10; store 0xFFFFFFFE to 0xFFFFFF00, two cycles later -> reads 0x00000000.
REQ-033 out_ready=0, push 1,2,3,4,5 -> STAT reads count=4, full=1, DROP=1; then out_ready=1 -> out_data 1,2,3,4 on successive cycles, then out_valid=0.
REQ-034 FIFO full, simultaneous push 9 and pop -> count stays 4, drained order ends ...,4,9; DROP unchanged.
REQ-035 DROP at 255 after 260 full pushes -> STAT[15:8]=0xFF; store to 0xFFFFFF08 -> reads 0.
REQ-036 FIFO holding 3 entries, reset=0 for one edge with concurrent push -> next cycle out_valid=0, STAT=0x10, CNT=0.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Processor data-memory port plus the outbound FIFO stream, bundled for the responder.
interface dmem_responder_if;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output memwrite, addr, writedata, out_ready,
        input  readdata, out_data, out_valid
    );

    modport slave (
        input  memwrite, addr, writedata, out_ready,
        output readdata, out_data, out_valid
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, free-running counter, a 4-entry output FIFO and a status
// register, all answering zero-latency loads for a single-cycle core.
module dmem_responder #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int          AW    = $clog2(RAM_WORDS);
    localparam logic [2:0]  DEPTH = 3'(FIFO_DEPTH);

    logic [31:0]   ram [RAM_WORDS];
    logic [31:0]   fifo_mem [4];
    logic [31:0]   cnt;
    logic [7:0]    drop;
    logic [2:0]    count;
    logic [1:0]    head_ptr;
    logic [1:0]    tail_ptr;

    logic          sel_ram;
    logic          sel_io;
    logic          sel_cnt;
    logic          sel_fifo;
    logic          sel_stat;
    logic [AW-1:0] ram_idx;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          drop_inc;
    logic [31:0]   stat;
    logic [31:0]   head_word;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^bus.addr[1:0];

    assign sel_ram  = (bus.addr[31:8] == 24'h000000);
    assign sel_io   = (bus.addr[31:8] == 24'hFFFFFF);
    assign sel_cnt  = sel_io && (bus.addr[7:2] == 6'd0);
    assign sel_fifo = sel_io && (bus.addr[7:2] == 6'd1);
    assign sel_stat = sel_io && (bus.addr[7:2] == 6'd2);
    assign ram_idx  = bus.addr[AW+1:2];

    assign full     = (count == DEPTH);
    assign empty    = (count == 3'd0);
    assign pop      = !empty && bus.out_ready;
    assign push_req = bus.memwrite && sel_fifo;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push     = push_req && (!full || pop);
    assign drop_inc = push_req && full && !pop;

    assign head_word = empty ? 32'd0 : fifo_mem[head_ptr];
    assign stat      = {16'd0, drop, 3'd0, empty, full, count};

    assign bus.out_data  = head_word;
    assign bus.out_valid = !empty;

    always_comb begin
        bus.readdata = 32'd0;
        if (sel_ram) begin
            bus.readdata = ram[ram_idx];
        end else if (sel_cnt) begin
            bus.readdata = cnt;
        end else if (sel_fifo) begin
            bus.readdata = head_word;
        end else if (sel_stat) begin
            bus.readdata = stat;
        end
    end

    // Storage arrays carry no reset; entries are only observable through count.
    always_ff @(posedge clk) begin
        if (reset && bus.memwrite && sel_ram) begin
            ram[ram_idx] <= bus.writedata;
        end
        if (reset && push) begin
            fifo_mem[tail_ptr] <= bus.writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= 32'd0;
            drop     <= 8'd0;
            count    <= 3'd0;
            head_ptr <= 2'd0;
            tail_ptr <= 2'd0;
        end else begin
            if (bus.memwrite && sel_cnt) begin
                cnt <= bus.writedata;
            end else begin
                cnt <= cnt + 32'd1;
            end

            if (bus.memwrite && sel_stat) begin
                drop <= 8'd0;
            end else if (drop_inc && (drop != 8'hFF)) begin
                drop <= drop + 8'd1;
            end

            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase

            if (pop) begin
                head_ptr <= head_ptr + 2'd1;
            end
            if (push) begin
                tail_ptr <= tail_ptr + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, counter, FIFO/drop counter and reset behaviour
// against hand-computed values.
module tb_dmem_responder;
    localparam logic [31:0] A_CNT  = 32'hFFFFFF00;
    localparam logic [31:0] A_FIFO = 32'hFFFFFF04;
    localparam logic [31:0] A_STAT = 32'hFFFFFF08;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    dmem_responder_if bus ();

    dmem_responder #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        chk(tag, bus.readdata, exp);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        bus.memwrite  = 1'b1;
        bus.addr      = a;
        bus.writedata = d;
        cyc();
        bus.memwrite  = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        bus.memwrite  = 1'b0;
        bus.addr      = 32'd0;
        bus.writedata = 32'd0;
        bus.out_ready = 1'b0;
        repeat (3) cyc();

        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        rd("rst_stat", A_STAT, 32'h0000_0010);
        rd("rst_cnt", A_CNT, 32'd0);

        // Counter: first increment on first edge out of reset.
        reset = 1'b1;
        cyc();
        rd("cnt_after_1", A_CNT, 32'd1);
        repeat (9) cyc();
        rd("cnt_after_10", A_CNT, 32'd10);
        st(A_CNT, 32'hFFFFFFFE);
        rd("cnt_load", A_CNT, 32'hFFFFFFFE);
        cyc();
        rd("cnt_max", A_CNT, 32'hFFFFFFFF);
        cyc();
        rd("cnt_wrap", A_CNT, 32'd0);

        // RAM
        st(32'h0000_0010, 32'hDEADBEEF);
        rd("ram_rd", 32'h0000_0010, 32'hDEADBEEF);
        rd("ram_rd_lsb", 32'h0000_0013, 32'hDEADBEEF);
        rd("unmapped_rd", 32'h0000_1010, 32'd0);
        bus.memwrite  = 1'b1;
        bus.addr      = 32'h0000_0010;
        bus.writedata = 32'h1234_5678;
        #1;
        chk("ram_same_cycle_old", bus.readdata, 32'hDEADBEEF);
        cyc();
        bus.memwrite = 1'b0;
        rd("ram_new", 32'h0000_0010, 32'h1234_5678);
        st(32'h0000_1010, 32'hCAFEF00D);
        rd("ram_unmapped_wr", 32'h0000_0010, 32'h1234_5678);
        st(32'hFFFF_FF0C, 32'h5555_5555);
        rd("io_other_rd", 32'hFFFF_FF0C, 32'd0);
        rd("stat_untouched", A_STAT, 32'h0000_0010);

        // FIFO fill with overflow, then drain.
        bus.memwrite  = 1'b1;
        bus.addr      = A_FIFO;
        bus.writedata = 32'd1;
        #1;
        chk("push_no_bypass", {31'd0, bus.out_valid}, 32'd0);
        cyc();
        bus.memwrite = 1'b0;
        chk("push_valid_next", {31'd0, bus.out_valid}, 32'd1);
        for (int i = 2; i <= 5; i++) st(A_FIFO, 32'(i));
        rd("fill_stat", A_STAT, 32'h0000_010C);
        rd("fifo_peek", A_FIFO, 32'd1);
        rd("fifo_peek_nopop", A_FIFO, 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain_%0d", i), bus.out_data, 32'(i));
            cyc();
        end
        chk("drain_empty_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("drain_empty_data", bus.out_data, 32'd0);
        cyc();
        rd("empty_ready_stat", A_STAT, 32'h0000_0110);

        // Full FIFO with simultaneous push and pop.
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) st(A_FIFO, 32'(i));
        bus.out_ready = 1'b1;
        st(A_FIFO, 32'd9);
        bus.out_ready = 1'b0;
        rd("full_pushpop_stat", A_STAT, 32'h0000_010C);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pp_drain_%0d", i), bus.out_data, (i == 3) ? 32'd9 : 32'(i + 2));
            cyc();
        end
        chk("pp_empty", {31'd0, bus.out_valid}, 32'd0);

        // DROP saturation and clear.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) st(A_FIFO, 32'(16 + i));
        for (int i = 0; i < 260; i++) st(A_FIFO, 32'hAAAA_0000 + 32'(i));
        rd("drop_sat", A_STAT, 32'h0000_FF0C);
        rd("fifo_head_kept", A_FIFO, 32'd16);
        st(A_STAT, 32'hFFFF_FFFF);
        rd("drop_clear", A_STAT, 32'h0000_000C);

        // Reset with three entries pending and a concurrent push/pop.
        bus.out_ready = 1'b1;
        repeat (4) cyc();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) st(A_FIFO, 32'(40 + i));
        rd("three_stat", A_STAT, 32'h0000_0003);
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        st(A_FIFO, 32'd77);
        reset         = 1'b1;
        bus.out_ready = 1'b0;
        chk("rst_mid_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_mid_data", bus.out_data, 32'd0);
        rd("rst_mid_stat", A_STAT, 32'h0000_0010);
        rd("rst_mid_cnt", A_CNT, 32'd0);
        cyc();
        rd("rst_mid_cnt_1", A_CNT, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
